// File: rtl/uart_alu_intf.sv
// Sequencer between UART RX, a combinational ALU and UART TX: collects A, B, opcode, then sends the result.
// Optional inter-byte timeout is enabled with `define UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned OP_W           = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done_tick,
  input  logic [7:0]        i_rx_data,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_tx_done_tick,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_op,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_rx_drop,
  output logic              o_timeout
);

  if (DATA_W > 8 || DATA_W == 0 || OP_W > 8 || OP_W == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_alu_intf: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_LOAD    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              timeout_q, timeout_d;
  logic              timeout_hit;

`ifdef UART_ALU_INTF_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles while parked in WAIT_B/WAIT_OP; any state change or accepted byte restarts it.
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_WAIT_B || state_q == S_WAIT_OP) && state_d == state_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and register updates; ticks outside the WAIT_* collection states are dropped.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    drop_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_WAIT_A: begin
        if (i_rx_done_tick) begin
          a_d     = i_rx_data[DATA_W-1:0];
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_rx_done_tick) begin
          b_d     = i_rx_data[DATA_W-1:0];
          state_d = S_WAIT_OP;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done_tick) begin
          op_d    = i_rx_data[OP_W-1:0];
          state_d = S_LOAD;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = S_WAIT_A;
        end
      end
      S_LOAD: begin
        tx_data_d = i_alu_result;
        drop_d    = i_rx_done_tick;
        state_d   = S_SEND;
      end
      S_SEND: begin
        drop_d  = i_rx_done_tick;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        drop_d = i_rx_done_tick;
        if (i_tx_done_tick) begin
          state_d = S_WAIT_A;
        end
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase
    tx_start_d = (state_d == S_SEND);
    busy_d     = (state_d == S_LOAD) || (state_d == S_SEND) || (state_d == S_WAIT_TX);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_rx_drop  = drop_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Randomised self-checking bench for uart_alu_intf with an a+b ALU stub and a transaction-level model.
module tb_uart_alu_intf;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx_done_tick;
  logic [7:0] i_rx_data;
  logic [7:0] i_alu_result;
  logic       i_tx_done_tick;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_rx_drop;
  logic       o_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected register contents, derived from the bytes accepted so far
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;

  always #5 i_clock = ~i_clock;

  assign i_alu_result = o_alu_a + o_alu_b;

  uart_alu_intf #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYCLES(10)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
    .i_alu_result(i_alu_result), .i_tx_done_tick(i_tx_done_tick),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
    .o_rx_drop(o_rx_drop), .o_timeout(o_timeout)
  );

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_done_tick = 1'b1;
    i_rx_data      = b;
    step();
    i_rx_done_tick = 1'b0;
    i_rx_data      = 8'($urandom);
  endtask

  task automatic tx_done();
    i_tx_done_tick = 1'b1;
    step();
    i_tx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_rx_data = 8'($urandom);
      step();
    end
  endtask

  // One full A/B/opcode/result transaction; optionally leaves the DUT waiting for the TX done tick.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap, input int delay, input bit drop, input bit finish);
    send_byte(a);
    m_a = a;
    n_cmp++; if (o_alu_a !== m_a) begin n_fail++; $display("FAIL txn_a: got %h expected %h", o_alu_a, m_a); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL txn_busy_a: got %b expected 0", o_busy); end
    idle(gap);
    send_byte(b);
    m_b = b;
    n_cmp++; if (o_alu_b !== m_b) begin n_fail++; $display("FAIL txn_b: got %h expected %h", o_alu_b, m_b); end
    idle(gap);
    send_byte(op);
    m_op = op[5:0];
    m_tx = 8'((int'(a) + int'(b)) % 256);
    n_cmp++; if (o_alu_op !== m_op) begin n_fail++; $display("FAIL txn_op: got %h expected %h", o_alu_op, m_op); end
    n_cmp++; if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL txn_load: start %b busy %b expected 0 1", o_tx_start, o_busy); end
    step();
    n_cmp++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL txn_start: got %b expected 1", o_tx_start); end
    n_cmp++; if (o_tx_data !== m_tx) begin n_fail++; $display("FAIL txn_tx_data: got %h expected %h", o_tx_data, m_tx); end
    step();
    n_cmp++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL txn_start_len: got %b expected 0", o_tx_start); end
    idle(delay);
    if (drop) begin
      send_byte(8'($urandom));
      n_cmp++; if (o_rx_drop !== 1'b1) begin n_fail++; $display("FAIL txn_drop: got %b expected 1", o_rx_drop); end
      n_cmp++; if (o_alu_a !== m_a || o_alu_b !== m_b || o_busy !== 1'b1) begin n_fail++; $display("FAIL txn_drop_hold: a %h b %h busy %b expected %h %h 1", o_alu_a, o_alu_b, o_busy, m_a, m_b); end
    end
    n_cmp++; if (o_tx_data !== m_tx) begin n_fail++; $display("FAIL txn_tx_hold: got %h expected %h", o_tx_data, m_tx); end
    if (finish) begin
      tx_done();
      n_cmp++; if (o_busy !== 1'b0 || o_rx_drop !== 1'b0) begin n_fail++; $display("FAIL txn_done: busy %b drop %b expected 0 0", o_busy, o_rx_drop); end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_rx_done_tick = 1'b0; i_tx_done_tick = 1'b0; i_rx_data = 8'h00;
    step();
    step();
    n_cmp++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data} !== 30'd0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h %h expected 0", o_alu_a, o_alu_b, o_alu_op, o_tx_data); end
    n_cmp++; if ({o_tx_start, o_busy, o_rx_drop, o_timeout} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {o_tx_start, o_busy, o_rx_drop, o_timeout}); end
    i_reset = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
    step();
  endtask

  task automatic test_basic();
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    m_a = 8'h05; m_b = 8'h03; m_op = 6'h20; m_tx = 8'h08;
    n_cmp++; if (o_alu_a !== 8'h05 || o_alu_b !== 8'h03 || o_alu_op !== 6'h20) begin n_fail++; $display("FAIL basic_operands: got %h %h %h expected 05 03 20", o_alu_a, o_alu_b, o_alu_op); end
    n_cmp++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_early: got %b expected 0", o_tx_start); end
    step();
    n_cmp++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h08) begin n_fail++; $display("FAIL basic_start: start %b data %h expected 1 08", o_tx_start, o_tx_data); end
    // Done tick sampled in the SEND cycle must be ignored
    i_tx_done_tick = 1'b1;
    step();
    i_tx_done_tick = 1'b0;
    n_cmp++; if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_send_done_ignored: start %b busy %b expected 0 1", o_tx_start, o_busy); end
    idle(3);
    n_cmp++; if (o_busy !== 1'b1 || o_tx_data !== 8'h08) begin n_fail++; $display("FAIL basic_wait_tx: busy %b data %h expected 1 08", o_busy, o_tx_data); end
    tx_done();
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: busy %b expected 0", o_busy); end
  endtask

  task automatic test_op_trunc();
    run_txn(8'($urandom), 8'($urandom), 8'hE2, 0, 1, 1'b0, 1'b1);
    n_cmp++; if (o_alu_op !== 6'h22) begin n_fail++; $display("FAIL op_trunc: got %h expected 22", o_alu_op); end
  endtask

  task automatic test_drop();
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 1, 2, 1'b1, 1'b1);
    run_txn(8'h11, 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b1);
    n_cmp++; if (o_alu_a !== 8'h11) begin n_fail++; $display("FAIL drop_next_a: got %h expected 11", o_alu_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, op;
    a = 8'($urandom); b = 8'($urandom); op = 8'($urandom);
    send_byte(a); send_byte(b); send_byte(op);
    m_a = a; m_b = b; m_op = op[5:0]; m_tx = a + b;
    // Fourth consecutive tick lands in LOAD and is discarded
    send_byte(8'($urandom));
    n_cmp++; if (o_rx_drop !== 1'b1 || o_tx_start !== 1'b1) begin n_fail++; $display("FAIL b2b_load_drop: drop %b start %b expected 1 1", o_rx_drop, o_tx_start); end
    n_cmp++; if (o_alu_a !== m_a || o_alu_b !== m_b || o_alu_op !== m_op || o_tx_data !== m_tx) begin n_fail++; $display("FAIL b2b_regs: got %h %h %h %h expected %h %h %h %h", o_alu_a, o_alu_b, o_alu_op, o_tx_data, m_a, m_b, m_op, m_tx); end
    step();
    n_cmp++; if (o_rx_drop !== 1'b0 || o_tx_start !== 1'b0) begin n_fail++; $display("FAIL b2b_after: drop %b start %b expected 0 0", o_rx_drop, o_tx_start); end
    tx_done();
  endtask

  task automatic test_reset_mid();
    bit saw_start;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    i_reset = 1'b1;
    #1;
    n_cmp++; if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_rx_drop, o_timeout} !== 34'd0) begin n_fail++; $display("FAIL reset_mid_async: got %h %h %h %h expected 0", o_alu_a, o_alu_b, o_alu_op, o_tx_data); end
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
    // Opcode tick while reset is held must not start anything
    i_rx_done_tick = 1'b1;
    step();
    i_rx_done_tick = 1'b0;
    i_reset = 1'b0;
    saw_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_tx_start === 1'b1) saw_start = 1'b1;
    end
    n_cmp++; if (saw_start !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_start: got %b expected 0", saw_start); end
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    logic [7:0] keep_a;
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 1'b0, 1'b0);
    keep_a = m_a;
    i_rx_done_tick = 1'b1; i_tx_done_tick = 1'b1; i_rx_data = 8'h99;
    step();
    i_rx_done_tick = 1'b0; i_tx_done_tick = 1'b0;
    n_cmp++; if (o_rx_drop !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL simul_drop: drop %b busy %b expected 1 0", o_rx_drop, o_busy); end
    n_cmp++; if (o_alu_a !== keep_a) begin n_fail++; $display("FAIL simul_a_hold: got %h expected %h", o_alu_a, keep_a); end
    run_txn(8'h3C, 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 1'($urandom), 1'b1);
      idle(int'($urandom_range(0, 3)));
    end
  endtask

`ifdef UART_ALU_INTF_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    logic [7:0] b;
    send_byte(8'h07);
    m_a = 8'h07;
    k = 0;
    for (int i = 1; i <= 30 && k == 0; i++) begin
      step();
      if (o_timeout === 1'b1) k = i;
    end
    n_cmp++; if (k !== 10) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 10", k); end
    step();
    n_cmp++; if (o_timeout !== 1'b0 || o_alu_a !== 8'h07) begin n_fail++; $display("FAIL timeout_pulse: to %b a %h expected 0 07", o_timeout, o_alu_a); end
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b1);
    // Byte arriving on the limit cycle wins over the timeout
    send_byte(8'($urandom));
    idle(9);
    b = 8'($urandom);
    send_byte(b);
    n_cmp++; if (o_timeout !== 1'b0 || o_alu_b !== b) begin n_fail++; $display("FAIL timeout_tick_wins: to %b b %h expected 0 %h", o_timeout, o_alu_b, b); end
    send_byte(8'($urandom));
    step();
    step();
    tx_done();
  endtask
`else
  task automatic test_timeout();
    bit saw_to;
    logic [7:0] b;
    send_byte(8'h07);
    saw_to = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_timeout !== 1'b0) saw_to = 1'b1;
    end
    n_cmp++; if (saw_to !== 1'b0) begin n_fail++; $display("FAIL no_timeout: got %b expected 0", saw_to); end
    b = 8'($urandom);
    send_byte(b);
    n_cmp++; if (o_alu_b !== b || o_alu_a !== 8'h07) begin n_fail++; $display("FAIL no_timeout_wait: a %h b %h expected 07 %h", o_alu_a, o_alu_b, b); end
    send_byte(8'($urandom));
    step();
    step();
    tx_done();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_op_trunc();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_simultaneous();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
